// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//   - SEG_* : logical glyphs, bit0 = segment a .. bit6 = segment g, 1 = lit
//   - A..G  : bit positions of the individual segments inside a glyph
//   - index_width(n) : width of a digit index for n digits, never below 1
package seven_segment_pkg;

  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;
  localparam int D = 3;
  localparam int E = 4;
  localparam int F = 5;
  localparam int G = 6;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111100;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1100111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  function automatic int index_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational BCD to seven-segment glyph decoder (logical polarity).
//   bcd_i : 4-bit digit value; 10..15 are not BCD and show a dash
//   seg_o : glyph, bit0 = a .. bit6 = g, 1 = lit
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// N-digit multiplexed seven-segment driver.
// A refresh prescaler divides clk into digit slots; at the end of each slot
// the scan index moves to the next digit. The first BLANK_CYCLES of each slot
// keep every digit enable inactive so the old glyph never ghosts onto the new
// digit. All outputs are registered and carry the configured pin polarity.
//   clk       : system clock
//   reset_n   : synchronous reset, active-low
//   load      : capture counts / dp_in into the display buffer
//   counts    : BCD digits, digit i = counts[4i+3:4i], digit 0 least significant
//   dp_in     : decimal point request per digit
//   blank_lz  : leading-zero blanking enable (live, not buffered)
//   segments  : bit0 = a .. bit6 = g
//   dp        : decimal point
//   digit_en  : one-hot digit enable (all inactive during blanking)
//   digit_idx : index of the digit whose data is on segments/dp
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter int BLANK_CYCLES   = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                load,
  input  logic [4*N_DIGITS-1:0]               counts,
  input  logic [N_DIGITS-1:0]                 dp_in,
  input  logic                                blank_lz,
  output logic [6:0]                          segments,
  output logic                                dp,
  output logic [N_DIGITS-1:0]                 digit_en,
  output logic [index_width(N_DIGITS)-1:0]    digit_idx
);

  localparam int   IW      = index_width(N_DIGITS);
  localparam int   PW      = (REFRESH_DIV <= 1) ? 1 : $clog2(REFRESH_DIV);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

  // Scan state and display buffer
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*N_DIGITS-1:0]   cnt_buf_q, cnt_buf_d;
  logic [N_DIGITS-1:0]     dp_buf_q, dp_buf_d;

  // Output registers (already in pin polarity)
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [N_DIGITS-1:0]     en_q, en_d;
  logic [IW-1:0]           didx_q, didx_d;

  logic                    tick;
  logic                    in_blank;
  logic [3:0]              sel_bcd;
  logic                    sel_dp;
  logic                    sel_lz;
  logic [N_DIGITS-1:0]     sel_onehot;
  logic [N_DIGITS-1:0]     lz_mask;
  logic                    zero_above;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_log;

  assign tick = (presc_q == PW'(REFRESH_DIV - 1));

  // Slot cycle equals the prescaler value; the comparison disappears
  // entirely when no blanking is configured.
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (presc_q < PW'(BLANK_CYCLES));
    end else begin : g_no_blank
      assign in_blank = 1'b0;
    end
  endgenerate

  // Prescaler, scan index and buffer next-state
  always_comb begin
    presc_d   = tick ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    if (tick) begin
      idx_d = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    cnt_buf_d = load ? counts : cnt_buf_q;
    dp_buf_d  = load ? dp_in  : dp_buf_q;
  end

  // Leading-zero mask: a digit is a leading zero when it and every more
  // significant digit are zero. Digit 0 always stays visible.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz_mask[i] = zero_above && (cnt_buf_q[4*i +: 4] == 4'd0);
      zero_above = lz_mask[i];
    end
  end

  // Select the addressed digit's data
  always_comb begin
    sel_bcd    = '0;
    sel_dp     = 1'b0;
    sel_lz     = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_bcd       = cnt_buf_q[4*i +: 4];
        sel_dp        = dp_buf_q[i];
        sel_lz        = lz_mask[i];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  seven_segment_decoder u_decoder (
    .bcd_i (sel_bcd),
    .seg_o (dec_seg)
  );

  // Output register inputs; polarity applied here so reset levels match pins
  always_comb begin
    seg_log = (blank_lz && sel_lz) ? SEG_OFF : dec_seg;
    seg_d   = seg_log ^ {7{SEG_INV}};
    dp_d    = sel_dp ^ SEG_INV;
    en_d    = (in_blank ? '0 : sel_onehot) ^ {N_DIGITS{DIG_INV}};
    didx_d  = idx_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      cnt_buf_q <= '0;
      dp_buf_q  <= '0;
      seg_q     <= {7{SEG_INV}};
      dp_q      <= SEG_INV;
      en_q      <= {N_DIGITS{DIG_INV}};
      didx_q    <= '0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      cnt_buf_q <= cnt_buf_d;
      dp_buf_q  <= dp_buf_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      en_q      <= en_d;
      didx_q    <= didx_d;
    end
  end

  assign segments  = seg_q;
  assign dp        = dp_q;
  assign digit_en  = en_q;
  assign digit_idx = didx_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: a 4-digit display, an active-low twin and
// a 2-digit single-cycle-slot variant share the same stimulus.
module tb_seven_segment_scanner;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] counts;
  logic [3:0]  dp_in;
  logic        blank_lz;

  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  digit_en;
  logic [1:0]  digit_idx;

  logic [6:0]  seg_pol;
  logic        dp_pol;
  logic [3:0]  en_pol;
  logic [1:0]  idx_pol;

  logic [6:0]  seg_deg;
  logic        dp_deg;
  logic [1:0]  en_deg;
  logic [0:0]  idx_deg;

  int n_checks;
  int n_errors;

  seven_segment_scanner #(
    .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .load(load), .counts(counts),
    .dp_in(dp_in), .blank_lz(blank_lz), .segments(segments), .dp(dp),
    .digit_en(digit_en), .digit_idx(digit_idx)
  );

  seven_segment_scanner #(
    .N_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) u_pol (
    .clk(clk), .reset_n(reset_n), .load(load), .counts(counts),
    .dp_in(dp_in), .blank_lz(blank_lz), .segments(seg_pol), .dp(dp_pol),
    .digit_en(en_pol), .digit_idx(idx_pol)
  );

  seven_segment_scanner #(
    .N_DIGITS(2), .REFRESH_DIV(1), .BLANK_CYCLES(0),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) u_deg (
    .clk(clk), .reset_n(reset_n), .load(load), .counts(counts[7:0]),
    .dp_in(dp_in[1:0]), .blank_lz(blank_lz), .segments(seg_deg), .dp(dp_deg),
    .digit_en(en_deg), .digit_idx(idx_deg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] oh4(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return one << d;
  endfunction

  // Step until u_dut shows digit d with its enable active, bounded.
  task automatic wait_digit(input int d);
    logic [1:0] dd;
    bit found;
    dd    = d[1:0];
    found = 1'b0;
    for (int c = 0; c < 64 && !found; c++) begin
      step();
      if (digit_idx == dd && digit_en == oh4(d)) found = 1'b1;
    end
    chk($sformatf("wait_digit%0d", d), {31'd0, found}, 32'd1);
  endtask

  task automatic load_data(input logic [15:0] c, input logic [3:0] p, input logic lz);
    counts   = c;
    dp_in    = p;
    blank_lz = lz;
    load     = 1'b1;
    step();
    load     = 1'b0;
  endtask

  // Table of {inputs, expected outputs} for the static display checks
  typedef struct {
    logic [15:0] cnt;
    logic [3:0]  dpv;
    logic        lz;
    int          dig;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t       vecs[17];
  logic [6:0] g1234[4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    load     = 1'b0;
    counts   = 16'h0000;
    dp_in    = 4'h0;
    blank_lz = 1'b0;

    vecs[0]  = '{16'h0050, 4'b0000, 1'b1, 3, 7'b0000000, 1'b0};
    vecs[1]  = '{16'h0050, 4'b0000, 1'b1, 2, 7'b0000000, 1'b0};
    vecs[2]  = '{16'h0050, 4'b0000, 1'b1, 1, 7'b1101101, 1'b0};
    vecs[3]  = '{16'h0050, 4'b0000, 1'b1, 0, 7'b0111111, 1'b0};
    vecs[4]  = '{16'h0050, 4'b0000, 1'b0, 3, 7'b0111111, 1'b0};
    vecs[5]  = '{16'h0050, 4'b0000, 1'b0, 2, 7'b0111111, 1'b0};
    vecs[6]  = '{16'h00F0, 4'b0010, 1'b0, 1, 7'b1000000, 1'b1};
    vecs[7]  = '{16'h00F0, 4'b0010, 1'b1, 2, 7'b0000000, 1'b0};
    vecs[8]  = '{16'h0000, 4'b0000, 1'b1, 1, 7'b0000000, 1'b0};
    vecs[9]  = '{16'h0000, 4'b0000, 1'b1, 0, 7'b0111111, 1'b0};
    vecs[10] = '{16'h8000, 4'b0000, 1'b1, 2, 7'b0111111, 1'b0};
    vecs[11] = '{16'h5678, 4'b0000, 1'b0, 0, 7'b1111111, 1'b0};
    vecs[12] = '{16'h5678, 4'b0000, 1'b0, 1, 7'b0000111, 1'b0};
    vecs[13] = '{16'h5678, 4'b0000, 1'b0, 3, 7'b1101101, 1'b0};
    vecs[14] = '{16'h0A00, 4'b0100, 1'b1, 2, 7'b1000000, 1'b1};
    vecs[15] = '{16'h0001, 4'b1000, 1'b1, 3, 7'b0000000, 1'b1};
    vecs[16] = '{16'h0900, 4'b0000, 1'b0, 2, 7'b1100111, 1'b0};
    g1234    = '{7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110};

    // Reset levels for both polarities and the 2-digit variant
    step(); step(); step();
    chk("rst_idx", {30'd0, digit_idx}, 32'd0);
    chk("rst_en",  {28'd0, digit_en},  32'd0);
    chk("rst_seg", {25'd0, segments},  32'd0);
    chk("rst_dp",  {31'd0, dp},        32'd0);
    chk("rst_pol_seg", {25'd0, seg_pol}, 32'h7f);
    chk("rst_pol_dp",  {31'd0, dp_pol},  32'd1);
    chk("rst_pol_en",  {28'd0, en_pol},  32'hf);
    chk("rst_deg_en",  {30'd0, en_deg},  32'd0);

    // Release with an immediate load of 1234; scan sequence and blanking
    reset_n = 1'b1;
    load    = 1'b1;
    counts  = 16'h1234;
    for (int k = 1; k <= 17; k++) begin
      int  ei;
      bit  eb;
      int  di;
      step();
      if (k == 1) load = 1'b0;
      ei = ((k - 1) / 4) % 4;
      eb = ((k - 1) % 4) == 0;
      di = (k - 1) % 2;
      chk($sformatf("scan_idx_k%0d", k), {30'd0, digit_idx}, ei);
      chk($sformatf("scan_en_k%0d", k), {28'd0, digit_en}, eb ? 32'd0 : {28'd0, oh4(ei)});
      if (k >= 2) chk($sformatf("scan_seg_k%0d", k), {25'd0, segments}, {25'd0, g1234[ei]});
      chk($sformatf("deg_idx_k%0d", k), {31'd0, idx_deg}, di);
      chk($sformatf("deg_en_k%0d", k), {30'd0, en_deg}, (di == 1) ? 32'd2 : 32'd1);
      if (k >= 2) chk($sformatf("deg_seg_k%0d", k), {25'd0, seg_deg},
                      (di == 1) ? 32'b1001111 : 32'b1100110);
    end

    // Load coinciding with the tick: scan must not break, new data next slot
    begin
      bit         found;
      logic [1:0] old_idx;
      int         ni;
      found = 1'b0;
      for (int c = 0; c < 16 && !found; c++) begin
        step();
        if (digit_en == 4'b0000) found = 1'b1;
      end
      chk("tick_find_blank", {31'd0, found}, 32'd1);
      step(); step();
      old_idx = digit_idx;
      load_data(16'h00F0, 4'b0010, 1'b0);
      chk("tick_idx_hold", {30'd0, digit_idx}, {30'd0, old_idx});
      chk("tick_en_hold", {28'd0, digit_en}, {28'd0, oh4(int'(old_idx))});
      step();
      ni = (int'(old_idx) + 1) % 4;
      chk("tick_idx_next", {30'd0, digit_idx}, ni);
      chk("tick_en_blank", {28'd0, digit_en}, 32'd0);
      chk("tick_seg_new", {25'd0, segments}, (ni == 1) ? 32'b1000000 : 32'b0111111);
      chk("tick_dp_new", {31'd0, dp}, (ni == 1) ? 32'd1 : 32'd0);
      wait_digit(1);
      chk("tick_dash_seg", {25'd0, segments}, 32'b1000000);
      chk("tick_dash_dp", {31'd0, dp}, 32'd1);
    end

    // Table-driven display checks
    for (int v = 0; v < 17; v++) begin
      load_data(vecs[v].cnt, vecs[v].dpv, vecs[v].lz);
      wait_digit(vecs[v].dig);
      chk($sformatf("vec%0d_seg", v), {25'd0, segments}, {25'd0, vecs[v].seg});
      chk($sformatf("vec%0d_dp", v), {31'd0, dp}, {31'd0, vecs[v].dpo});
    end

    // Active-low twin showing "8"
    load_data(16'h8888, 4'b0000, 1'b0);
    wait_digit(1);
    chk("pol_idx", {30'd0, idx_pol}, 32'd1);
    chk("pol_seg8", {25'd0, seg_pol}, 32'd0);
    chk("pol_dp", {31'd0, dp_pol}, 32'd1);
    chk("pol_en", {28'd0, en_pol}, 32'b1101);

    // Reset in the middle of digit 2's slot
    load_data(16'h5678, 4'b1111, 1'b0);
    wait_digit(2);
    reset_n = 1'b0;
    step();
    chk("mid_rst_idx", {30'd0, digit_idx}, 32'd0);
    chk("mid_rst_en",  {28'd0, digit_en},  32'd0);
    chk("mid_rst_seg", {25'd0, segments},  32'd0);
    chk("mid_rst_dp",  {31'd0, dp},        32'd0);
    chk("mid_rst_pol_en", {28'd0, en_pol}, 32'hf);
    reset_n = 1'b1;
    step();
    chk("post_rst_idx_k1", {30'd0, digit_idx}, 32'd0);
    chk("post_rst_en_k1",  {28'd0, digit_en},  32'd0);
    chk("post_rst_seg_k1", {25'd0, segments},  32'b0111111);
    step();
    chk("post_rst_en_k2",  {28'd0, digit_en},  32'b0001);
    chk("post_rst_seg_k2", {25'd0, segments},  32'b0111111);
    chk("post_rst_dp_k2",  {31'd0, dp},        32'd0);
    wait_digit(3);
    chk("post_rst_d3_seg", {25'd0, segments},  32'b0111111);
    chk("post_rst_d3_dp",  {31'd0, dp},        32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised N-digit multiplexed seven-segment driver for the frequency counter display. It generalises the two-digit driver in four ways:
- digit count is a parameter;
- digit switching runs on a programmable refresh prescaler;
- digit enables are blanked around each switch to prevent ghosting;
- it adds leading-zero blanking, decimal points, an overflow glyph and selectable output polarity.

It sits between the counter/BCD stage and the board pins.

Parameters:
N_DIGITS, 4, number of BCD digits scanned (2..8)
REFRESH_DIV, 1000, clk cycles per digit slot (>=1)
BLANK_CYCLES, 2, cycles at the start of each slot with all digit enables inactive (0 = none; must be < REFRESH_DIV)
SEG_ACTIVE_LOW, 0, 1 = segments/dp driven active-low (common anode)
DIG_ACTIVE_LOW, 0, 1 = digit enables driven active-low

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous reset, active-low
load  in  1  capture counts/dp_in into display buffer
counts  in  4*N_DIGITS  BCD digits; digit i = counts[4i+3:4i]; digit 0 = least significant
dp_in  in  N_DIGITS  decimal point request per digit
blank_lz  in  1  enable leading-zero blanking (live, not buffered)
segments  out  7  bit0=a .. bit6=g, registered
dp  out  1  decimal point, registered
digit_en  out  N_DIGITS  one-hot digit enable, registered
digit_idx  out  $clog2(N_DIGITS) (min 1)  index of the digit currently addressed, registered

Behaviour:
- Reset (reset_n low at a clk edge):
  - buffers = 0, prescaler = 0, scan index = 0;
  - segments, dp = inactive level (all 0 logical, polarity applied);
  - digit_en = all inactive; digit_idx = 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. Tick = (prescaler == REFRESH_DIV-1). With REFRESH_DIV = 1, tick is asserted every cycle.
- Scan index: on tick, advances by 1; N_DIGITS-1 wraps to 0. Scanning never stalls; load does not reset or pause it.
- Load: on a cycle with load = 1, the count and dp buffers capture counts and dp_in. If load and tick coincide, both take effect.
- Output register, every cycle, from current index and current buffers:
  - digit_idx <= index;
  - segments <= decode(buf[index]), blanked if required;
  - dp <= dp_buf[index];
  - digit_en <= one-hot(index), but all inactive while slot cycle < BLANK_CYCLES (slot cycle = prescaler value).
- Latency:
  - index change visible on outputs 1 cycle after the tick edge;
  - loaded data visible 1 cycle after the load edge (2 cycles after load is asserted).
- Decode (logical, before polarity):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111;
  - 10..15 = 1000000 (dash, overflow/invalid indicator).
- Leading-zero blanking, when blank_lz = 1:
  - digit i > 0 is blanked (segments all off) if buf[i] == 0 and every buf[j], j > i, is 0;
  - digit 0 is never blanked;
  - dp is not affected by blanking.
- Polarity: SEG_ACTIVE_LOW inverts segments and dp; DIG_ACTIVE_LOW inverts digit_en. Applied at the output register input, so reset levels are polarity-correct.
- Reset mid-slot or mid-load: reset wins. Outputs take reset values on the next edge and scanning restarts at digit 0 with prescaler 0.
- At most one digit_en bit is ever active.

Decomposition:
- Package seven_segment_pkg:
  - glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - segment bit-index localparams A..G;
  - function index_width(n).
- Sub-module seven_segment_decoder: combinational 4-bit to 7-bit logical glyph. Instantiated once, on the selected digit.

Test Plan:
1. Reset → scan:
   - Setup: N_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1; release reset, load counts=0x1234.
   - Required: digit_idx steps 0,1,2,3,0 every 4 cycles.
   - Required: segments 1100110, 1001111, 1011011, 0000110 ("4","3","2","1").
   - Required: digit_en low for the first cycle of each slot.
2. Leading-zero blanking:
   - Stimulus: load counts=0x0050, blank_lz=1.
   - Required: digits 3 and 2 show segments 0000000; digit 1 shows 1101101; digit 0 shows 0111111.
   - Required: with blank_lz=0, digits 3 and 2 show 0111111.
3. Load during tick, overflow, dp:
   - Stimulus: load 0x00F0 with dp_in=0010 on a tick cycle.
   - Required: digit 1 shows 1000000 with dp=1.
   - Required: scan sequence is unbroken.
4. Polarity:
   - Setup: SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1.
   - Required in reset: segments=1111111, dp=1, digit_en=1111.
   - Required: digit "8" drives segments=0000000.
5. Mid-slot reset:
   - Stimulus: assert reset_n=0 while digit_idx=2.
   - Required: next edge gives digit_idx=0, digit_en inactive, buffers zero.
   - Required: after release, digit 0 shows "0".
6. Degenerate config:
   - Setup: REFRESH_DIV=1, BLANK_CYCLES=0, N_DIGITS=2.
   - Required: digit_idx toggles every cycle; digit_en alternates 01/10 with no gap.
